// File: rtl/elm_pkg.sv
// Shared constants and types for the ELM output layer.
// Class sums settle COUNT_MAX cycles into accumulation; argmax runs after that.
package elm_pkg;

  localparam int SUM_W       = 24;
  localparam int NUM_CLASSES = 10;
  localparam int COUNT_MAX   = 255;
  localparam int DIGIT_W     = 4;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

endpackage

// File: rtl/elm_argmax_classifier_if.sv
// Start/busy/done handshake and result bus of the argmax stage.
interface elm_argmax_classifier_if #(
  parameter int NUM_CLASSES = elm_pkg::NUM_CLASSES,
  parameter int SUM_W       = elm_pkg::SUM_W
);

  logic                           start;
  logic [NUM_CLASSES*SUM_W-1:0]   scores;
  logic                           busy;
  logic                           done;
  logic [elm_pkg::DIGIT_W-1:0]    digit;
  logic [SUM_W-1:0]               max_score;
  logic [SUM_W:0]                 margin;

  modport master (
    output start, scores,
    input  busy, done, digit, max_score, margin
  );

  modport slave (
    input  start, scores,
    output busy, done, digit, max_score, margin
  );

endinterface

// File: rtl/elm_score_cmp.sv
// Single-step running max/second-max update for the argmax scan.
// An equal-to-best score keeps the earlier index but may still become second.
module elm_score_cmp #(
  parameter int SUM_W = elm_pkg::SUM_W
) (
  input  logic signed [SUM_W-1:0] s,
  input  logic signed [SUM_W-1:0] best,
  input  logic signed [SUM_W-1:0] second,
  input  logic                    first,
  output logic signed [SUM_W-1:0] best_nxt,
  output logic signed [SUM_W-1:0] second_nxt,
  output logic                    take_new
);

  always_comb begin
    best_nxt   = best;
    second_nxt = second;
    take_new   = 1'b0;
    if (first) begin
      best_nxt   = s;
      second_nxt = {1'b1, {(SUM_W-1){1'b0}}};
      take_new   = 1'b1;
    end else if (s > best) begin
      best_nxt   = s;
      second_nxt = best;
      take_new   = 1'b1;
    end else if (s > second) begin
      second_nxt = s;
    end
  end

endmodule

// File: rtl/elm_argmax_classifier.sv
// Sequential argmax over the ELM class sums: captures on start, scans one
// class per clock, reports digit, max score and margin to the runner-up.
module elm_argmax_classifier
  import elm_pkg::*;
#(
  parameter int NUM_CLASSES = elm_pkg::NUM_CLASSES,
  parameter int SUM_W       = elm_pkg::SUM_W
) (
  input  logic                   clk,
  input  logic                   rst,
  elm_argmax_classifier_if.slave bus
);

  state_t                   state;
  logic signed [SUM_W-1:0]  regs [NUM_CLASSES];
  logic [DIGIT_W-1:0]       idx;
  logic [DIGIT_W-1:0]       best_idx;
  logic signed [SUM_W-1:0]  best;
  logic signed [SUM_W-1:0]  second;

  logic signed [SUM_W-1:0]  s;
  logic signed [SUM_W-1:0]  best_nxt;
  logic signed [SUM_W-1:0]  second_nxt;
  logic                     take_new;
  logic                     last;
  logic [SUM_W:0]           diff;

  always_comb begin
    s    = regs[idx];
    last = (idx == DIGIT_W'(NUM_CLASSES-1));
    // Sign-extend both operands so max - second cannot wrap.
    diff = {best_nxt[SUM_W-1], best_nxt} - {second_nxt[SUM_W-1], second_nxt};
  end

  elm_score_cmp #(
    .SUM_W(SUM_W)
  ) u_cmp (
    .s          (s),
    .best       (best),
    .second     (second),
    .first      (idx == '0),
    .best_nxt   (best_nxt),
    .second_nxt (second_nxt),
    .take_new   (take_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      best_idx      <= '0;
      best          <= '0;
      second        <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.digit     <= '0;
      bus.max_score <= '0;
      bus.margin    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
              regs[k] <= bus.scores[k*SUM_W +: SUM_W];
            end
            idx      <= '0;
            state    <= SCAN;
            bus.busy <= 1'b1;
          end
        end
        SCAN: begin
          best   <= best_nxt;
          second <= second_nxt;
          if (take_new) begin
            best_idx <= idx;
          end
          if (last) begin
            bus.digit     <= take_new ? idx : best_idx;
            bus.max_score <= best_nxt;
            bus.margin    <= diff;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elm_argmax_classifier.sv
// Directed vector bench for elm_argmax_classifier.
module tb_elm_argmax_classifier;
  import elm_pkg::*;

  localparam int N = NUM_CLASSES;
  localparam int W = SUM_W;

  typedef struct {
    string  name;
    int     sc [N];
    int     dig;
    int     mx;
    longint mg;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elm_argmax_classifier_if #(.NUM_CLASSES(N), .SUM_W(W)) bus ();

  elm_argmax_classifier #(.NUM_CLASSES(N), .SUM_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total  = 0;
  int   passed = 0;
  vec_t vecs [8];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t v);
    for (int k = 0; k < N; k++) bus.scores[k*W +: W] = W'(v.sc[k]);
  endtask

  // Counts edges (starting from 'already') until done is seen, bounded.
  task automatic wait_done(input int already, output int edges);
    edges = already;
    while (bus.done !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic check_result(input vec_t v);
    check({v.name, "_done"},   longint'(bus.done), 1);
    check({v.name, "_busy"},   longint'(bus.busy), 0);
    check({v.name, "_digit"},  longint'(bus.digit), v.dig);
    check({v.name, "_max"},    longint'($signed(bus.max_score)), v.mx);
    check({v.name, "_margin"}, longint'(bus.margin), v.mg);
  endtask

  task automatic run_vec(input vec_t v);
    int e;
    load(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({v.name, "_busy_after_e0"}, longint'(bus.busy), 1);
    wait_done(1, e);
    check({v.name, "_latency"}, e, 11);
    check_result(v);
    tick();
    check({v.name, "_done_pulse"}, longint'(bus.done), 0);
    check({v.name, "_hold_digit"}, longint'(bus.digit), v.dig);
  endtask

  initial begin
    int e;
    int dcount;

    for (int k = 0; k < N; k++) vecs[0].sc[k] = k * 100;
    vecs[0].name = "distinct"; vecs[0].dig = 9; vecs[0].mx = 900; vecs[0].mg = 100;

    vecs[1].name = "negative";
    vecs[1].sc = '{-2000, -3000, -1500, -5, -1200, -8000, -4000, -1000, -2500, -9999};
    vecs[1].dig = 3; vecs[1].mx = -5; vecs[1].mg = 995;

    vecs[2].name = "tie";
    vecs[2].sc = '{0, 0, 4000, 0, 0, 0, 4000, 0, 0, 0};
    vecs[2].dig = 2; vecs[2].mx = 4000; vecs[2].mg = 0;

    vecs[3].name = "extreme";
    for (int k = 0; k < N; k++) vecs[3].sc[k] = -8388608;
    vecs[3].sc[0] = 8388607;
    vecs[3].dig = 0; vecs[3].mx = 8388607; vecs[3].mg = 64'd16777215;

    vecs[4].name = "all_equal";
    for (int k = 0; k < N; k++) vecs[4].sc[k] = 7;
    vecs[4].dig = 0; vecs[4].mx = 7; vecs[4].mg = 0;

    vecs[5].name = "last_wins";
    for (int k = 0; k < N; k++) vecs[5].sc[k] = -3;
    vecs[5].sc[0] = 49; vecs[5].sc[9] = 50;
    vecs[5].dig = 9; vecs[5].mx = 50; vecs[5].mg = 1;

    vecs[6].name = "second_late";
    vecs[6].sc = '{1000, 10, 999, 0, 0, 0, 0, 0, 0, 0};
    vecs[6].dig = 0; vecs[6].mx = 1000; vecs[6].mg = 1;

    vecs[7].name = "all_min";
    for (int k = 0; k < N; k++) vecs[7].sc[k] = -8388608;
    vecs[7].dig = 0; vecs[7].mx = -8388608; vecs[7].mg = 0;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.scores = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy",   longint'(bus.busy), 0);
    check("rst_done",   longint'(bus.done), 0);
    check("rst_digit",  longint'(bus.digit), 0);
    check("rst_max",    longint'(bus.max_score), 0);
    check("rst_margin", longint'(bus.margin), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // start during SCAN at E3 must not disturb the capture
    load(vecs[0]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    load(vecs[2]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ignore_busy", longint'(bus.busy), 1);
    wait_done(4, e);
    check("ignore_latency", e, 11);
    check_result(vecs[0]);

    // start in the done cycle is accepted
    load(vecs[1]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b2b_done_low", longint'(bus.done), 0);
    check("b2b_busy", longint'(bus.busy), 1);
    check("b2b_hold_digit", longint'(bus.digit), 9);
    wait_done(1, e);
    check("b2b_latency", e, 11);
    check_result(vecs[1]);
    tick();

    // reset at E5 aborts the scan
    load(vecs[5]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("abort_busy",   longint'(bus.busy), 0);
    check("abort_done",   longint'(bus.done), 0);
    check("abort_digit",  longint'(bus.digit), 0);
    check("abort_max",    longint'(bus.max_score), 0);
    check("abort_margin", longint'(bus.margin), 0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done === 1'b1) dcount++;
    end
    check("abort_no_done", dcount, 0);
    run_vec(vecs[6]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
